// File: rtl/vector_accumulate.sv
// rtl/vector_accumulate.sv - registered adder-tree reduction of product lanes with per-packet signed accumulation
// Beats shift through L tree levels, then sum into the packet accumulator; one result per datain_last.

module vector_accumulate #(
  parameter int C_OP_WIDTH    = 16,
  parameter int C_NUM_LANES   = 8,
  parameter int C_ACCUM_WIDTH = 40,
  parameter int C_CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_OP_WIDTH*C_NUM_LANES-1:0] datain,
  input  logic                              datain_valid,
  input  logic                              datain_last,
  output logic                              datain_ready,
  output logic [C_ACCUM_WIDTH-1:0]          dout,
  output logic [C_CNT_WIDTH-1:0]            dout_count,
  output logic                              dout_ovf,
  output logic                              dout_valid,
  input  logic                              dout_ready
);

  localparam int L  = $clog2(C_NUM_LANES);
  localparam int TW = C_OP_WIDTH + L;

  logic en;

  // A held result with no taker freezes every stage, including the input.
  assign en           = !(dout_valid && !dout_ready);
  assign datain_ready = !rst && en;

  for (genvar s = 0; s < L; s++) begin : g_lvl
    localparam int N = C_NUM_LANES >> (s + 1);
    localparam int W = C_OP_WIDTH + s + 1;
    logic signed [W-1:0] sum_q [N];
    logic signed [W-1:0] sum_d [N];
    for (genvar i = 0; i < N; i++) begin : g_node
      logic signed [W-2:0] a;
      logic signed [W-2:0] b;
      if (s == 0) begin : g_in
        assign a = datain[(2*i)*C_OP_WIDTH +: C_OP_WIDTH];
        assign b = datain[(2*i+1)*C_OP_WIDTH +: C_OP_WIDTH];
      end else begin : g_up
        assign a = g_lvl[s-1].sum_q[2*i];
        assign b = g_lvl[s-1].sum_q[2*i+1];
      end
      assign sum_d[i] = en ? (W'(a) + W'(b)) : sum_q[i];
    end
    always_ff @(posedge clk) begin
      sum_q <= sum_d;
    end
  end

  logic signed [TW-1:0] tree_out;
  assign tree_out = g_lvl[L-1].sum_q[0];

  logic [L-1:0] vld_q, vld_d;
  logic [L-1:0] lst_q, lst_d;

  always_comb begin
    vld_d = vld_q;
    lst_d = lst_q;
    if (en) begin
      vld_d[0] = datain_valid;
      lst_d[0] = datain_valid && datain_last;
      for (int k = 1; k < L; k++) begin
        vld_d[k] = vld_q[k-1];
        lst_d[k] = lst_q[k-1];
      end
    end
  end

  logic signed [C_ACCUM_WIDTH-1:0] acc_q, acc_d;
  logic                            ovf_q, ovf_d;
  logic [C_CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic                            start_q, start_d;
  logic [C_ACCUM_WIDTH-1:0]        dout_q, dout_d;
  logic [C_CNT_WIDTH-1:0]          dout_count_q, dout_count_d;
  logic                            dout_ovf_q, dout_ovf_d;
  logic                            dout_valid_q, dout_valid_d;

  logic signed [C_ACCUM_WIDTH-1:0] sum_ext, base, acc_new;
  logic                            add_ovf, ovf_new;
  logic [C_CNT_WIDTH-1:0]          cnt_new;

  assign sum_ext = C_ACCUM_WIDTH'(tree_out);
  assign base    = start_q ? '0 : acc_q;
  assign acc_new = base + sum_ext;
  assign add_ovf = (base[C_ACCUM_WIDTH-1] == sum_ext[C_ACCUM_WIDTH-1]) &&
                   (acc_new[C_ACCUM_WIDTH-1] != base[C_ACCUM_WIDTH-1]);
  assign ovf_new = (!start_q && ovf_q) || add_ovf;
  assign cnt_new = start_q ? C_CNT_WIDTH'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

  always_comb begin
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    start_d      = start_q;
    dout_d       = dout_q;
    dout_count_d = dout_count_q;
    dout_ovf_d   = dout_ovf_q;
    dout_valid_d = dout_valid_q;
    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
    // A new result may load in the same cycle the previous one is taken.
    if (en && vld_q[L-1]) begin
      if (lst_q[L-1]) begin
        dout_d       = acc_new;
        dout_count_d = cnt_new;
        dout_ovf_d   = ovf_new;
        dout_valid_d = 1'b1;
        start_d      = 1'b1;
      end else begin
        acc_d   = acc_new;
        ovf_d   = ovf_new;
        cnt_d   = cnt_new;
        start_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      lst_q        <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      start_q      <= 1'b1;
      dout_q       <= '0;
      dout_count_q <= '0;
      dout_ovf_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      lst_q        <= lst_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      dout_q       <= dout_d;
      dout_count_q <= dout_count_d;
      dout_ovf_q   <= dout_ovf_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_count = dout_count_q;
  assign dout_ovf   = dout_ovf_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_vector_accumulate.sv
// tb/tb_vector_accumulate.sv - self-checking bench for vector_accumulate (40-bit and 20-bit accumulator instances)

module tb_vector_accumulate;

  localparam int OPW  = 16;
  localparam int NL   = 8;
  localparam int ACC  = 40;
  localparam int ACC2 = 20;
  localparam int CW   = 16;
  localparam int DW   = OPW * NL;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  datain;
  logic           datain_valid, datain_last, dout_ready;
  logic           ready1, ready2, valid1, valid2, ovf1, ovf2;
  logic [ACC-1:0] dout1;
  logic [ACC2-1:0] dout2;
  logic [CW-1:0]  cnt1, cnt2;

  always #5 clk = ~clk;

  vector_accumulate #(.C_OP_WIDTH(OPW), .C_NUM_LANES(NL), .C_ACCUM_WIDTH(ACC), .C_CNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst(rst), .datain(datain), .datain_valid(datain_valid), .datain_last(datain_last),
    .datain_ready(ready1), .dout(dout1), .dout_count(cnt1), .dout_ovf(ovf1), .dout_valid(valid1),
    .dout_ready(dout_ready));

  vector_accumulate #(.C_OP_WIDTH(OPW), .C_NUM_LANES(NL), .C_ACCUM_WIDTH(ACC2), .C_CNT_WIDTH(CW)) dut2 (
    .clk(clk), .rst(rst), .datain(datain), .datain_valid(datain_valid), .datain_last(datain_last),
    .datain_ready(ready2), .dout(dout2), .dout_count(cnt2), .dout_ovf(ovf2), .dout_valid(valid2),
    .dout_ready(dout_ready));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: exact integer packet sums, wrapped to each accumulator width.
  typedef struct { logic [ACC-1:0] d; logic [CW-1:0] c; bit o; } res_t;
  res_t    exp1[$];
  res_t    exp2[$];
  longint  acc1m, acc2m, s_m, t_m;
  bit      ov1m, ov2m, startm = 1'b1;
  int      cntm;
  res_t    r;
  bit      stall_prev = 1'b0;
  logic [ACC-1:0] stall_dout;

  function automatic longint wrapw(input longint v, input int w);
    longint m, x;
    m = longint'(1) << w;
    x = v % m;
    if (x < 0) x += m;
    if (x >= m / 2) x -= m;
    return x;
  endfunction

  function automatic bit fits(input longint v, input int w);
    longint h;
    h = longint'(1) << (w - 1);
    return (v < h) && (v >= -h);
  endfunction

  function automatic longint lane_sum(input logic [DW-1:0] d);
    longint s = 0;
    for (int i = 0; i < NL; i++) s += longint'($signed(d[i*OPW +: OPW]));
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      startm = 1'b1;
      cntm = 0;
      exp1.delete();
      exp2.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_dout", dout1, stall_dout);
        chk("stall_hold_valid", valid1, 1);
        chk("stall_ready", ready1, dout_ready);
      end
      stall_prev = valid1 && !dout_ready;
      stall_dout = dout1;
      if (valid1 && dout_ready) begin
        if (exp1.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_result: got dout=%0h, expected no result", dout1);
        end else begin
          r = exp1.pop_front();
          chk("sb_dout", dout1, r.d);
          chk("sb_count", cnt1, r.c);
          chk("sb_ovf", ovf1, r.o);
        end
        if (exp2.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_result_w20: got dout=%0h, expected no result", dout2);
        end else begin
          r = exp2.pop_front();
          chk("sb_dout_w20", dout2, r.d[ACC2-1:0]);
          chk("sb_ovf_w20", ovf2, r.o);
          chk("sb_valid_w20", valid2, 1);
        end
      end
      if (datain_valid && ready1) begin
        s_m = lane_sum(datain);
        if (startm) begin
          acc1m = 0; acc2m = 0; ov1m = 0; ov2m = 0; cntm = 0;
        end
        t_m = acc1m + s_m;
        if (!fits(t_m, ACC)) ov1m = 1;
        acc1m = wrapw(t_m, ACC);
        t_m = acc2m + s_m;
        if (!fits(t_m, ACC2)) ov2m = 1;
        acc2m = wrapw(t_m, ACC2);
        if (cntm < 65535) cntm++;
        startm = 1'b0;
        if (datain_last) begin
          exp1.push_back('{ACC'(acc1m), CW'(cntm), ov1m});
          exp2.push_back('{ACC'(acc2m), CW'(cntm), ov2m});
          startm = 1'b1;
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input int gap);
    int n = 0;
    datain = d;
    datain_valid = 1'b1;
    datain_last = last;
    while (!ready1 && n < 100) begin
      step();
      n++;
    end
    if (!ready1) begin
      errors++; checks++;
      $display("FAIL accept_timeout: got datain_ready=0, expected 1 within 100 cycles");
    end
    step();
    datain_valid = 1'b0;
    datain_last = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_result();
    int n = 0;
    while (!valid1 && n < 40) begin
      step();
      n++;
    end
    if (!valid1) begin
      errors++; checks++;
      $display("FAIL result_timeout: got dout_valid=0, expected 1 within 40 cycles");
    end
  endtask

  function automatic logic [DW-1:0] build(input logic [OPW-1:0] lane, input bit incr);
    logic [DW-1:0] d;
    for (int i = 0; i < NL; i++) d[i*OPW +: OPW] = incr ? OPW'(i + 1) : lane;
    return d;
  endfunction

  typedef struct {
    logic [OPW-1:0] lane;
    bit             incr;
    int             nbeats;
    int             gap;
    logic [ACC-1:0] exp_dout;
    logic [CW-1:0]  exp_cnt;
    bit             exp_ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'd0,    1'b1, 1, 0, 40'd36,          16'd1, 1'b0};
    tbl[1] = '{16'hFFFF, 1'b0, 3, 0, 40'hFFFFFFFFE8,  16'd3, 1'b0};
    tbl[2] = '{16'd3,    1'b0, 4, 2, 40'd96,          16'd4, 1'b0};
    tbl[3] = '{16'd3,    1'b0, 4, 0, 40'd96,          16'd4, 1'b0};
    tbl[4] = '{16'h8000, 1'b0, 2, 1, 40'hFFFFF80000,  16'd2, 1'b0};
    tbl[5] = '{16'h7FFF, 1'b0, 1, 3, 40'd262136,      16'd1, 1'b0};

    rst = 1'b1; datain = '0; datain_valid = 1'b0; datain_last = 1'b0; dout_ready = 1'b1;
    repeat (3) step();
    chk("rst_dout", dout1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_ready", ready1, 0);
    chk("rst_dout_w20", dout2, 0);
    rst = 1'b0;
    step();

    begin : latency
      int n = 0;
      send_beat(build('0, 1'b1), 1'b1, 0);
      while (!valid1 && n < 20) begin
        step();
        n++;
      end
      chk("latency", n + 1, 4);
      chk("lat_dout", dout1, 36);
      step();
      chk("lat_one_cycle", valid1, 0);
    end

    for (int t = 0; t < 6; t++) begin
      for (int b = 0; b < tbl[t].nbeats; b++)
        send_beat(build(tbl[t].lane, tbl[t].incr), b == tbl[t].nbeats - 1,
                  (b == tbl[t].nbeats - 1) ? 0 : tbl[t].gap);
      wait_result();
      chk($sformatf("tbl%0d_dout", t), dout1, tbl[t].exp_dout);
      chk($sformatf("tbl%0d_count", t), cnt1, tbl[t].exp_cnt);
      chk($sformatf("tbl%0d_ovf", t), ovf1, tbl[t].exp_ovf);
      step();
    end

    dout_ready = 1'b0;
    send_beat(build(16'd1, 1'b0), 1'b1, 0);
    send_beat(build(16'd2, 1'b0), 1'b1, 0);
    repeat (8) step();
    chk("bp_valid", valid1, 1);
    chk("bp_dout", dout1, 8);
    chk("bp_ready", ready1, 0);
    dout_ready = 1'b1;
    step();
    chk("bp_second_valid", valid1, 1);
    chk("bp_second_dout", dout1, 16);
    step();
    chk("bp_drained", valid1, 0);
    chk("bp_retain_dout", dout1, 16);

    for (int b = 0; b < 5; b++) send_beat(build(16'h7FFF, 1'b0), b == 4, 0);
    wait_result();
    chk("ovf_dout_w20", dout2, 20'd262104);
    chk("ovf_flag_w20", ovf2, 1);
    chk("ovf_count_w20", cnt2, 5);
    chk("ovf_dout_w40", dout1, 40'd1310680);
    chk("ovf_flag_w40", ovf1, 0);
    step();
    send_beat(build(16'd1, 1'b0), 1'b1, 0);
    wait_result();
    chk("ovf_clear_dout_w20", dout2, 8);
    chk("ovf_clear_flag_w20", ovf2, 0);
    step();

    send_beat(build(16'd1, 1'b0), 1'b0, 0);
    send_beat(build(16'd1, 1'b0), 1'b0, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_dout", dout1, 0);
    chk("mid_rst_valid", valid1, 0);
    chk("mid_rst_ready", ready1, 0);
    rst = 1'b0;
    repeat (6) step();
    chk("mid_rst_no_output", valid1, 0);
    send_beat(build(16'd1, 1'b0), 1'b1, 0);
    wait_result();
    chk("mid_rst_dout_after", dout1, 8);
    chk("mid_rst_count_after", cnt1, 1);
    step();

    for (int c = 0; c < 600; c++) begin
      datain       = {$urandom, $urandom, $urandom, $urandom};
      datain_valid = ($urandom_range(0, 3) != 0);
      datain_last  = ($urandom_range(0, 3) == 0);
      dout_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    datain_valid = 1'b0;
    datain_last  = 1'b0;
    dout_ready   = 1'b1;
    repeat (20) step();
    chk("drain_queue", exp1.size(), 0);
    chk("drain_queue_w20", exp2.size(), 0);
    chk("drain_valid", valid1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_accumulate.md
Name: vector_accumulate

Overview:
- Downstream stage of the vector multiplier.
- Consumes a vector of C_NUM_LANES products per beat and reduces each beat through a registered adder tree.
- Accumulates the beat sums across a packet delimited by datain_last and emits one signed dot-product result per packet.
- Uses ready/valid handshakes on both sides and carries backpressure through the whole pipeline.

Parameters:
- C_OP_WIDTH, 16: width of each signed product lane.
- C_NUM_LANES, 8: lanes per beat; must be a power of two and at least 2.
- C_ACCUM_WIDTH, 40: signed accumulator and result width; must be at least C_OP_WIDTH + log2(C_NUM_LANES).
- C_CNT_WIDTH, 16: width of the per-packet beat counter.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- datain  in  C_OP_WIDTH*C_NUM_LANES  lane i occupies bits [i*C_OP_WIDTH +: C_OP_WIDTH], two's complement.
- datain_valid  in  1  a beat is present on datain.
- datain_last  in  1  marks the final beat of a packet; qualified by datain_valid.
- datain_ready  out  1  the block accepts a beat this cycle.
- dout  out  C_ACCUM_WIDTH  signed packet sum.
- dout_count  out  C_CNT_WIDTH  number of beats in the reported packet.
- dout_ovf  out  1  signed overflow occurred while accumulating the reported packet.
- dout_valid  out  1  dout, dout_count and dout_ovf hold a result.
- dout_ready  in  1  the consumer takes the result this cycle.

Behaviour:
- Reset values: dout=0, dout_count=0, dout_ovf=0, dout_valid=0, datain_ready=0 while rst=1.
  - Every pipeline valid bit, the accumulator, the beat counter and the overflow flag clear.
  - A partially accumulated packet is discarded.
- Global advance: en = !(dout_valid && !dout_ready); datain_ready = !rst && en.
  - A beat is accepted when datain_valid && datain_ready.
  - All pipeline stages (data, valid, last) shift only when en=1; when en=0 every stage holds.
- Adder tree:
  - L = log2(C_NUM_LANES) registered levels; each level sums adjacent pairs.
  - Lane values are sign-extended; level k is C_OP_WIDTH+k bits wide, so the tree itself never overflows.
  - Bubbles (valid=0) propagate through the tree and are ignored by the accumulate stage.
- Accumulate stage, acting on a valid tree output when en=1:
  - sum_ext = tree output sign-extended to C_ACCUM_WIDTH.
  - base = 0 if the packet-start flag is set, else acc; new = base + sum_ext, wrapping modulo 2^C_ACCUM_WIDTH.
  - ovf_new = (packet-start ? 0 : ovf) OR signed overflow of this add, i.e. operand signs equal and result sign differs.
  - cnt_new = (packet-start ? 1 : cnt+1), saturating at 2^C_CNT_WIDTH-1.
  - Non-last beat: acc, ovf and cnt take the new values; packet-start clears.
  - Last beat: dout=new, dout_ovf=ovf_new, dout_count=cnt_new, dout_valid=1; packet-start sets.
  - The packet-start flag is 1 after reset.
- Output register:
  - While dout_valid=1 and dout_ready=0, all outputs stay stable and the pipeline stalls.
  - dout_valid=1 with dout_ready=1 and a new last beat in the same cycle: the new result loads and dout_valid stays 1.
  - dout_valid=1 with dout_ready=1 and no new last beat: dout_valid drops to 0; dout, dout_count and dout_ovf retain their values.
- Latency: the beat carrying datain_last, accepted in cycle t with no stall, produces dout_valid=1 in cycle t+L+1 (t+4 for 8 lanes).
  - Throughput is one beat per cycle while dout_ready is held high.
- Single-beat packet (last on the first beat): the count is 1 and dout equals that beat's lane sum.
- datain_last on a beat with datain_valid=0 is ignored.

Test Plan:
- Single beat, lanes = 1,2,...,8, last=1, dout_ready=1 -> dout=36, dout_count=1, dout_ovf=0, dout_valid exactly 4 cycles after acceptance, for one cycle.
- Three beats, all lanes 0xFFFF (-1), last on beat 3 -> dout=-24 (0xFFFFFFFFE8), dout_count=3, dout_ovf=0.
- Backpressure:
  - Setup: dout_ready=0; two back-to-back single-beat packets, lanes all 1 then all 2.
  - Expect dout=8 held stable and datain_ready=0 while stalled.
  - Raising dout_ready gives 8 accepted, then 16 on the next result; no beat is lost or duplicated.
- Overflow:
  - Setup: C_ACCUM_WIDTH=20; five beats of all lanes 0x7FFF.
  - Expect dout=262104 (1310680 mod 2^20), dout_ovf=1, dout_count=5.
  - A following packet with lanes all 1 reports dout_ovf=0.
- Reset mid-packet:
  - Setup: two non-last beats of all 1s, rst high for 1 cycle, then one beat of all 1s with last.
  - Expect dout=8, dout_count=1, and no output for the aborted packet.
- Bubbles: a 4-beat packet of all-lane value 3 with datain_valid low for 2 cycles between each beat -> dout=96, dout_count=4, identical to the contiguous case.
